// File: rtl/bp_be_redirect_gen.sv
// bp_be_redirect_gen
//   Turns the integer pipe's resolved branch/jump result into frontend commands.
//   A mispredicted, 4B-aligned target is captured and offered to the FE command
//   queue as a held valid/ready redirect. Resolution is then fenced until the
//   frontend delivers the first instruction of the new path. A correct
//   prediction produces a one-cycle attaboy training pulse. A mispredicted but
//   misaligned target raises a one-cycle misalign pulse instead of a redirect.
//
// Ports
//   clk_i, reset_i       clock, synchronous active-high reset
//   resolve_v_i          valid branch/jump resolving in the int pipe this cycle
//   resolve_pc_i         PC of the resolving instruction
//   resolve_tgt_i        resolved next PC
//   resolve_pred_i       next PC predicted by fetch
//   flush_i              commit-stage flush; highest priority, returns to IDLE
//   fe_v_i, fe_pc_i      instruction delivered by the frontend and its PC
//   redirect_ready_i     FE command queue accepts the redirect
//   redirect_v_o         redirect command valid (held until accepted)
//   redirect_pc_o        redirect target
//   attaboy_v_o          correct-prediction pulse
//   attaboy_pc_o         PC of the correctly predicted instruction
//   poison_o             combinational squash of the current int-pipe resolve
//   misalign_v_o         resolved target not 4B-aligned (pulse)
//   mispred_cnt_o        saturating count of redirect-causing mispredicts

module bp_be_redirect_gen #(
  parameter int unsigned vaddr_width_p = 39,
  parameter int unsigned cnt_width_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     resolve_v_i,
  input  logic [vaddr_width_p-1:0] resolve_pc_i,
  input  logic [vaddr_width_p-1:0] resolve_tgt_i,
  input  logic [vaddr_width_p-1:0] resolve_pred_i,

  input  logic                     flush_i,

  input  logic                     fe_v_i,
  input  logic [vaddr_width_p-1:0] fe_pc_i,

  input  logic                     redirect_ready_i,
  output logic                     redirect_v_o,
  output logic [vaddr_width_p-1:0] redirect_pc_o,

  output logic                     attaboy_v_o,
  output logic [vaddr_width_p-1:0] attaboy_pc_o,

  output logic                     poison_o,
  output logic                     misalign_v_o,
  output logic [cnt_width_p-1:0]   mispred_cnt_o
);

  localparam logic [1:0] state_idle_lp  = 2'd0;
  localparam logic [1:0] state_send_lp  = 2'd1;
  localparam logic [1:0] state_fence_lp = 2'd2;

  localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;

  logic [1:0]               state_q,       state_d;
  logic [vaddr_width_p-1:0] tgt_q,         tgt_d;
  logic                     redirect_v_q,  redirect_v_d;
  logic                     attaboy_v_q,   attaboy_v_d;
  logic [vaddr_width_p-1:0] attaboy_pc_q,  attaboy_pc_d;
  logic                     misalign_v_q,  misalign_v_d;
  logic [cnt_width_p-1:0]   cnt_q,         cnt_d;

  logic mispred;
  logic tgt_aligned;
  logic in_idle;
  logic redirect_cause;
  logic fence_release;

  // Resolve classification
  assign mispred        = resolve_v_i & (resolve_tgt_i != resolve_pred_i);
  assign tgt_aligned    = (resolve_tgt_i[1:0] == 2'b00);
  assign in_idle        = (state_q == state_idle_lp);
  // A flush in the same cycle pre-empts the redirect, so it does not count as a cause
  assign redirect_cause = in_idle & mispred & tgt_aligned & ~flush_i;
  assign fence_release  = fe_v_i & (fe_pc_i == tgt_q);

  // Squash any resolve while a redirect is outstanding, and everything younger
  // than the instruction that causes a redirect in IDLE
  assign poison_o = resolve_v_i & (~in_idle | redirect_cause);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    redirect_v_d = redirect_v_q;
    attaboy_v_d  = 1'b0;
    attaboy_pc_d = attaboy_pc_q;
    misalign_v_d = 1'b0;
    cnt_d        = cnt_q;

    if (flush_i) begin
      // Drops any pending redirect, even one being accepted this cycle
      state_d      = state_idle_lp;
      redirect_v_d = 1'b0;
    end else begin
      case (state_q)
        state_idle_lp: begin
          if (resolve_v_i) begin
            if (mispred) begin
              if (tgt_aligned) begin
                tgt_d        = resolve_tgt_i;
                redirect_v_d = 1'b1;
                state_d      = state_send_lp;
                cnt_d        = (cnt_q == cnt_max_lp) ? cnt_q
                                                     : cnt_q + cnt_width_p'(1);
              end else begin
                misalign_v_d = 1'b1;
              end
            end else begin
              attaboy_v_d  = 1'b1;
              attaboy_pc_d = resolve_pc_i;
            end
          end
        end

        state_send_lp: begin
          // Command held stable until accepted; acceptance drops valid at the same edge
          if (redirect_ready_i) begin
            redirect_v_d = 1'b0;
            state_d      = state_fence_lp;
          end
        end

        state_fence_lp: begin
          // Wrong-path deliveries are ignored; only the redirect target ends the fence
          if (fence_release) begin
            state_d = state_idle_lp;
          end
        end

        default: begin
          state_d      = state_idle_lp;
          redirect_v_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= state_idle_lp;
      tgt_q        <= '0;
      redirect_v_q <= 1'b0;
      attaboy_v_q  <= 1'b0;
      attaboy_pc_q <= '0;
      misalign_v_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      redirect_v_q <= redirect_v_d;
      attaboy_v_q  <= attaboy_v_d;
      attaboy_pc_q <= attaboy_pc_d;
      misalign_v_q <= misalign_v_d;
      cnt_q        <= cnt_d;
    end
  end

  assign redirect_v_o  = redirect_v_q;
  assign redirect_pc_o = tgt_q;
  assign attaboy_v_o   = attaboy_v_q;
  assign attaboy_pc_o  = attaboy_pc_q;
  assign misalign_v_o  = misalign_v_q;
  assign mispred_cnt_o = cnt_q;

endmodule
